pool_window_scheduler: RTL and testbench

- Controller that sequences a max-pooling pass over a feature map stored in a single-port RAM. One pass is started by a start pulse.
- For each output pixel it walks the POOL x POOL window:
  - issues one RAM read per element,
  - reduces the returned samples to a signed running maximum,
  - writes the result to the output buffer through a valid/ready write port.
- Sits between the convolution output buffer and the dense-layer input buffer, and replaces free-running window indexing with a start/busy/done handshake and backpressure.

---
 rtl/pool_window_scheduler_if.sv | 27 ++
 rtl/pool_window_scheduler.sv | 164 ++++++++++++++++
 tb/tb_pool_window_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_window_scheduler_if.sv
// Handshake and memory-port bundle between the pooling scheduler, the
// input feature-map RAM and the output buffer.
interface pool_window_scheduler_if #(
    parameter int WIDTH_BIT = 16,
    parameter int ADDR_W    = 16
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        rd_en;
    logic [ADDR_W-1:0]           rd_addr;
    logic signed [WIDTH_BIT-1:0] rd_data;
    logic                        wr_en;
    logic                        wr_ready;
    logic [ADDR_W-1:0]           wr_addr;
    logic signed [WIDTH_BIT-1:0] wr_data;

    modport master (
        input  start, rd_data, wr_ready,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, wr_ready,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_window_scheduler.sv
// Max-pooling pass sequencer: walks every POOL x POOL window of every channel,
// reads each element from a 1-cycle-latency RAM, keeps a signed running
// maximum and hands each window result to the output buffer via valid/ready.
module pool_window_scheduler #(
    parameter int IN_SIZE   = 28,
    parameter int POOL      = 2,
    parameter int STRIDE    = 2,
    parameter int CHANNELS  = 1,
    parameter int WIDTH_BIT = 16,
    parameter int ADDR_W    = 16
) (
    input logic                    clock,
    input logic                    reset,
    pool_window_scheduler_if.master bus
);
    localparam int OUT_SIZE = (IN_SIZE - POOL) / STRIDE + 1;
    localparam int LAST_K   = POOL * POOL - 1;

    typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;

    state_t state;
    int     ch, oi, oj;
    int     k, kx, ky;
    int     nxt_ch, nxt_oi, nxt_oj;
    logic   last_win;

    // Read-return pipeline: vld_p1 marks a sample on rd_data this cycle,
    // first_p1 marks it as element 0 of its window.
    logic                        vld_p1;
    logic                        first_p1;
    logic signed [WIDTH_BIT-1:0] max_p1;

    function automatic logic [ADDR_W-1:0] in_addr(input int c, input int i, input int j,
                                                  input int wy, input int wx);
        int a;
        a = c * IN_SIZE * IN_SIZE + (i * STRIDE + wy) * IN_SIZE + (j * STRIDE + wx);
        return ADDR_W'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] out_addr(input int c, input int i, input int j);
        int a;
        a = c * OUT_SIZE * OUT_SIZE + i * OUT_SIZE + j;
        return ADDR_W'(a);
    endfunction

    // First sample loads directly; later ones win only when strictly greater,
    // so ties keep the earlier value.
    function automatic logic signed [WIDTH_BIT-1:0] reduce_max(
        input logic signed [WIDTH_BIT-1:0] cur,
        input logic signed [WIDTH_BIT-1:0] smp,
        input logic                        first);
        return (first || (smp > cur)) ? smp : cur;
    endfunction

    // Next output-pixel position (oj fastest, then oi, then channel).
    always_comb begin
        nxt_ch   = ch;
        nxt_oi   = oi;
        nxt_oj   = oj + 1;
        last_win = (ch == CHANNELS - 1) && (oi == OUT_SIZE - 1) && (oj == OUT_SIZE - 1);
        if (oj == OUT_SIZE - 1) begin
            nxt_oj = 0;
            nxt_oi = oi + 1;
            if (oi == OUT_SIZE - 1) begin
                nxt_oi = 0;
                nxt_ch = ch + 1;
            end
        end
    end

    // Controller FSM with registered outputs plus the running-max datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            ch          <= 0;
            oi          <= 0;
            oj          <= 0;
            k           <= 0;
            kx          <= 0;
            ky          <= 0;
            vld_p1      <= 1'b0;
            first_p1    <= 1'b0;
        end else begin
            // ---- stage p1: sample returned by the RAM
            vld_p1   <= bus.rd_en;
            first_p1 <= bus.rd_en && (k == 0);
            if (vld_p1) begin
                max_p1 <= reduce_max(max_p1, bus.rd_data, first_p1);
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ch          <= 0;
                        oi          <= 0;
                        oj          <= 0;
                        k           <= 0;
                        kx          <= 0;
                        ky          <= 0;
                        bus.busy    <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= in_addr(0, 0, 0, 0, 0);
                        state       <= READ;
                    end
                end
                READ: begin
                    if (k == LAST_K) begin
                        bus.rd_en <= 1'b0;
                        state     <= LAST;
                    end else begin
                        k <= k + 1;
                        if (kx == POOL - 1) begin
                            kx          <= 0;
                            ky          <= ky + 1;
                            bus.rd_addr <= in_addr(ch, oi, oj, ky + 1, 0);
                        end else begin
                            kx          <= kx + 1;
                            bus.rd_addr <= in_addr(ch, oi, oj, ky, kx + 1);
                        end
                    end
                end
                LAST: begin
                    // Final sample arrives this cycle; fold it straight into the result.
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= out_addr(ch, oi, oj);
                    bus.wr_data <= reduce_max(max_p1, bus.rd_data, first_p1);
                    state       <= WRITE;
                end
                WRITE: begin
                    if (bus.wr_ready) begin
                        bus.wr_en <= 1'b0;
                        if (last_win) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            ch          <= nxt_ch;
                            oi          <= nxt_oi;
                            oj          <= nxt_oj;
                            k           <= 0;
                            kx          <= 0;
                            ky          <= 0;
                            bus.rd_en   <= 1'b1;
                            bus.rd_addr <= in_addr(nxt_ch, nxt_oi, nxt_oj, 0, 0);
                            state       <= READ;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_window_scheduler.sv
// Directed and randomized bench for pool_window_scheduler: four DUT
// configurations share one clock; a behavioural window-max model predicts
// every read address, write, and the done latency.
module tb_pool_window_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_all;
    logic ready;
    int   sel;
    int   checks   = 0;
    int   failures = 0;

    localparam int P_IN [4] = '{4, 2, 3, 4};
    localparam int P_ST [4] = '{2, 2, 1, 2};
    localparam int P_CH [4] = '{1, 1, 1, 2};

    pool_window_scheduler_if #(.WIDTH_BIT(16), .ADDR_W(16)) bus0();
    pool_window_scheduler_if #(.WIDTH_BIT(16), .ADDR_W(16)) bus1();
    pool_window_scheduler_if #(.WIDTH_BIT(16), .ADDR_W(16)) bus2();
    pool_window_scheduler_if #(.WIDTH_BIT(16), .ADDR_W(16)) bus3();

    pool_window_scheduler #(.IN_SIZE(4), .POOL(2), .STRIDE(2), .CHANNELS(1), .WIDTH_BIT(16), .ADDR_W(16))
        dut0 (.clock(clk), .reset(rst), .bus(bus0));
    pool_window_scheduler #(.IN_SIZE(2), .POOL(2), .STRIDE(2), .CHANNELS(1), .WIDTH_BIT(16), .ADDR_W(16))
        dut1 (.clock(clk), .reset(rst), .bus(bus1));
    pool_window_scheduler #(.IN_SIZE(3), .POOL(2), .STRIDE(1), .CHANNELS(1), .WIDTH_BIT(16), .ADDR_W(16))
        dut2 (.clock(clk), .reset(rst), .bus(bus2));
    pool_window_scheduler #(.IN_SIZE(4), .POOL(2), .STRIDE(2), .CHANNELS(2), .WIDTH_BIT(16), .ADDR_W(16))
        dut3 (.clock(clk), .reset(rst), .bus(bus3));

    assign bus0.start = start_all && (sel == 0);
    assign bus1.start = start_all && (sel == 1);
    assign bus2.start = start_all && (sel == 2);
    assign bus3.start = start_all && (sel == 3);
    assign bus0.wr_ready = ready;
    assign bus1.wr_ready = ready;
    assign bus2.wr_ready = ready;
    assign bus3.wr_ready = ready;

    logic signed [15:0] mem [4][64];

    // Single-port RAM models with one cycle read latency.
    always @(posedge clk) begin
        if (bus0.rd_en) bus0.rd_data <= mem[0][bus0.rd_addr[5:0]];
        if (bus1.rd_en) bus1.rd_data <= mem[1][bus1.rd_addr[5:0]];
        if (bus2.rd_en) bus2.rd_data <= mem[2][bus2.rd_addr[5:0]];
        if (bus3.rd_en) bus3.rd_data <= mem[3][bus3.rd_addr[5:0]];
    end

    // View of the currently selected DUT.
    logic               v_busy, v_done, v_rd_en, v_wr_en;
    logic [15:0]        v_rd_addr, v_wr_addr;
    logic signed [15:0] v_wr_data;
    always_comb begin
        v_busy = bus0.busy; v_done = bus0.done; v_rd_en = bus0.rd_en; v_wr_en = bus0.wr_en;
        v_rd_addr = bus0.rd_addr; v_wr_addr = bus0.wr_addr; v_wr_data = bus0.wr_data;
        case (sel)
            1: begin
                v_busy = bus1.busy; v_done = bus1.done; v_rd_en = bus1.rd_en; v_wr_en = bus1.wr_en;
                v_rd_addr = bus1.rd_addr; v_wr_addr = bus1.wr_addr; v_wr_data = bus1.wr_data;
            end
            2: begin
                v_busy = bus2.busy; v_done = bus2.done; v_rd_en = bus2.rd_en; v_wr_en = bus2.wr_en;
                v_rd_addr = bus2.rd_addr; v_wr_addr = bus2.wr_addr; v_wr_data = bus2.wr_data;
            end
            3: begin
                v_busy = bus3.busy; v_done = bus3.done; v_rd_en = bus3.rd_en; v_wr_en = bus3.wr_en;
                v_rd_addr = bus3.rd_addr; v_wr_addr = bus3.wr_addr; v_wr_data = bus3.wr_data;
            end
            default: ;
        endcase
    end

    // Transaction logs of the selected DUT, plus read/write overlap watch on all.
    int wlog_a[$];
    int wlog_d[$];
    int rlog_a[$];
    int overlap = 0;
    int done_seen = 0;
    always @(posedge clk) begin
        if (v_wr_en && ready) begin
            wlog_a.push_back(int'(v_wr_addr));
            wlog_d.push_back(int'(v_wr_data));
        end
        if (v_rd_en) rlog_a.push_back(int'(v_rd_addr));
        if (v_done) done_seen <= done_seen + 1;
        if ((bus0.rd_en && bus0.wr_en) || (bus1.rd_en && bus1.wr_en) ||
            (bus2.rd_en && bus2.wr_en) || (bus3.rd_en && bus3.wr_en))
            overlap <= overlap + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int out_size(input int id);
        return (P_IN[id] - 2) / P_ST[id] + 1;
    endfunction

    // Plain window maximum from the specification's addressing rule.
    function automatic int exp_max(input int id, input int c, input int oi, input int oj);
        int n, best, v;
        n    = P_IN[id];
        best = -(1 << 30);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 2; x++) begin
                v = int'(mem[id][c * n * n + (oi * P_ST[id] + y) * n + oj * P_ST[id] + x]);
                if (v > best) best = v;
            end
        return best;
    endfunction

    function automatic int exp_win(input int id, input int w);
        int o, c, r;
        o = out_size(id);
        c = w / (o * o);
        r = w % (o * o);
        return exp_max(id, c, r / o, r % o);
    endfunction

    task automatic run_pass(input int id, input int stall_win, input int stall_n, input bit mid_start);
        int n, done_n, stalled, o, nw, idx;
        int exp_rd[$];
        sel = id;
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        stalled = 0;
        o  = out_size(id);
        nw = P_CH[id] * o * o;
        @(negedge clk);
        start_all = 1'b1;
        ready     = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        start_all = 1'b0;
        chk("busy_after_start", v_busy, 1);
        done_n = -1;
        while (n < 400) begin
            if (v_wr_en && (wlog_a.size() == stall_win) && (stalled < stall_n)) begin
                ready = 1'b0;
                stalled++;
                chk("stall_wr_en", v_wr_en, 1);
                chk("stall_wr_addr", v_wr_addr, stall_win);
                chk("stall_wr_data", v_wr_data, exp_win(id, stall_win));
            end else begin
                ready = 1'b1;
            end
            start_all = (mid_start && n == 8);
            @(posedge clk);
            n++;
            @(negedge clk);
            if (v_done) begin
                done_n = n;
                break;
            end
        end
        start_all = 1'b0;
        ready     = 1'b1;
        chk("done_edge", done_n, nw * 6 + stall_n);
        chk("busy_in_done", v_busy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", v_done, 0);
        chk("busy_after_done", v_busy, 0);
        chk("write_count", wlog_a.size(), nw);
        for (int i = 0; i < nw && i < wlog_a.size(); i++) begin
            chk("wr_addr", wlog_a[i], i);
            chk("wr_data", wlog_d[i], exp_win(id, i));
        end
        for (int c = 0; c < P_CH[id]; c++)
            for (int i = 0; i < o; i++)
                for (int j = 0; j < o; j++)
                    for (int y = 0; y < 2; y++)
                        for (int x = 0; x < 2; x++)
                            exp_rd.push_back(c * P_IN[id] * P_IN[id] + (i * P_ST[id] + y) * P_IN[id] + j * P_ST[id] + x);
        chk("read_count", rlog_a.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rlog_a.size(); i++) begin
            idx = i;
            chk("rd_addr", rlog_a[idx], exp_rd[idx]);
        end
    endtask

    initial begin
        rst = 1'b1; start_all = 1'b0; ready = 1'b1; sel = 0;
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 64; i++) mem[m][i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 4; id++) begin
            sel = id;
            #1;
            chk("rst_busy", v_busy, 0);
            chk("rst_done", v_done, 0);
            chk("rst_rd_en", v_rd_en, 0);
            chk("rst_wr_en", v_wr_en, 0);
            chk("rst_rd_addr", v_rd_addr, 0);
            chk("rst_wr_addr", v_wr_addr, 0);
            chk("rst_wr_data", v_wr_data, 0);
        end
        rst = 1'b0;
        sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_no_read", v_rd_en, 0);

        // 4x4 ramp: results 5, 7, 13, 15, done after 24 edges.
        for (int i = 0; i < 16; i++) mem[0][i] = 16'(i);
        run_pass(0, -1, 0, 1'b0);
        chk("ramp_w0", exp_win(0, 0), 5);
        chk("ramp_w3", exp_win(0, 3), 15);

        // Negative window and all-equal window on a 2x2 map.
        mem[1][0] = -16'sd5; mem[1][1] = -16'sd3; mem[1][2] = -16'sd8; mem[1][3] = -16'sd7;
        run_pass(1, -1, 0, 1'b0);
        if (wlog_d.size() > 0) chk("neg_window", wlog_d[0], -3);
        for (int i = 0; i < 4; i++) mem[1][i] = 16'sd4;
        run_pass(1, -1, 0, 1'b0);
        if (wlog_d.size() > 0) chk("tie_window", wlog_d[0], 4);

        // Overlapping windows with stride 1.
        for (int i = 0; i < 9; i++) mem[2][i] = 16'(i);
        run_pass(2, -1, 0, 1'b0);
        if (rlog_a.size() >= 4) begin
            chk("s1_rd0", rlog_a[0], 0);
            chk("s1_rd1", rlog_a[1], 1);
            chk("s1_rd2", rlog_a[2], 3);
            chk("s1_rd3", rlog_a[3], 4);
        end

        // Backpressure on window 1 (addr 1, data 7) for 3 cycles, plus a stray start mid-pass.
        run_pass(0, 1, 3, 1'b0);
        run_pass(0, -1, 0, 1'b1);

        // Two channels: second channel reads from base 16, writes 4..7.
        for (int i = 0; i < 32; i++) mem[3][i] = 16'($urandom);
        run_pass(3, -1, 0, 1'b0);
        if (rlog_a.size() > 16) chk("ch1_base", rlog_a[16], 16);

        // Randomized maps with random backpressure.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) mem[0][i] = 16'($urandom);
            run_pass(0, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0);
        end

        // Reset during READ of window 1 aborts the pass.
        for (int i = 0; i < 16; i++) mem[0][i] = 16'(i);
        sel = 0;
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        @(negedge clk);
        start_all = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_all = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_rd_en", v_rd_en, 1);
        done_seen = 0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", v_busy, 0);
        chk("abort_rd_en", v_rd_en, 0);
        chk("abort_wr_en", v_wr_en, 0);
        chk("abort_rd_addr", v_rd_addr, 0);
        chk("abort_wr_addr", v_wr_addr, 0);
        chk("abort_wr_data", v_wr_data, 0);
        chk("abort_done", v_done, 0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("abort_no_done", done_seen, 0);
        chk("abort_writes", wlog_a.size(), 1);
        chk("abort_idle", v_busy, 0);
        run_pass(0, -1, 0, 1'b0);

        chk("no_read_during_write", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
